// File: rtl/vga_pkg.sv
// vga_pkg: shared timing constants and types for the 640x480@60 Hz VGA path.
//   - VGA_* constants : default horizontal/vertical timing (pixels / lines)
//   - VGA_H/V_TOTAL   : full line length and full frame height
//   - CNT_W / ADDR_W  : counter and pixel-address widths
//   - rgb_t           : packed {R,G,B} 24-bit colour
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Both counters (max 799 / 524) and both addresses fit in 10 bits.
  localparam int CNT_W  = 10;
  localparam int ADDR_W = 10;

  typedef logic [23:0] rgb_t;

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: width-generic shift register of DEPTH stages that advances
// only on enabled edges. Every stage loads rst_val on asynchronous reset, so
// the caller chooses the inactive value of each bit (e.g. 1 for active-low
// syncs). DEPTH = 0 degenerates to a wire.
// Ports:
//   clk     in          clock
//   reset   in          asynchronous active-low reset
//   clken   in          shift enable; low holds every stage
//   rst_val in  [W-1:0] value loaded into every stage on reset
//   din     in  [W-1:0] data entering stage 0
//   dout    out [W-1:0] data leaving the last stage
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clken,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= rst_val;
        end else if (clken) begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel-clock timing generator and DAC output stage.
// Counts columns/lines, publishes the active pixel address upstream, and
// drives an aligned hsync/vsync/valid/RGB bundle DATA_LAT+1 enabled cycles
// after the counter value it describes.
// Optional feature macro: VGA_SYNC_FRAME_CNT_EN enables sof and frame_cnt;
// without it both outputs are tied to 0.
// Ports:
//   clk        in      pixel clock
//   reset      in      asynchronous active-low reset
//   clken      in      pixel enable; low freezes all state
//   pixel_data in  24  {R,G,B} for the address issued DATA_LAT enabled cycles ago
//   h_addr     out 10  active column (0 in blanking), combinational
//   v_addr     out 10  active line (0 in blanking), combinational
//   hsync      out     active-low horizontal sync
//   vsync      out     active-low vertical sync
//   valid      out     visible pixel
//   red/green/blue out 8 each colour, 0 whenever valid is low
//   sof        out     one-cycle start-of-frame pulse
//   frame_cnt  out 16  frame counter, wraps 65535 -> 0
//
// Output handshake: valid has no ready partner. The DAC cannot stall, so a
// pixel is consumed on every enabled edge where valid is high, and the RGB
// value on the same cycle belongs to that pixel; when valid is low RGB is 0.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int DATA_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clken,
  input  logic [23:0]       pixel_data,
  output logic [ADDR_W-1:0] h_addr,
  output logic [ADDR_W-1:0] v_addr,
  output logic              hsync,
  output logic              vsync,
  output logic              valid,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              sof,
  output logic [15:0]       frame_cnt
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Line/frame order is sync, back porch, active, front porch.
  localparam int H_ACT_LO = H_SYNC + H_BP;
  localparam int H_ACT_HI = H_ACT_LO + H_ACTIVE;
  localparam int V_ACT_LO = V_SYNC + V_BP;
  localparam int V_ACT_HI = V_ACT_LO + V_ACTIVE;

  // Control bundle carried through the alignment pipe: {hsync, vsync, valid[, sof]}.
`ifdef VGA_SYNC_FRAME_CNT_EN
  localparam int CTRL_W = 4;
  localparam logic [CTRL_W-1:0] CTRL_RST = 4'b1100;
`else
  localparam int CTRL_W = 3;
  localparam logic [CTRL_W-1:0] CTRL_RST = 3'b110;
`endif

  logic [CNT_W-1:0]  h_cnt, v_cnt;
  logic              h_in, v_in;
  logic [CTRL_W-1:0] ctrl_raw, ctrl_dly, ctrl_q;
  rgb_t              rgb_q;

  // Column/line counters; v_cnt advances (and wraps) on the same edge h_cnt wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (clken) begin
      if (h_cnt == CNT_W'(H_TOTAL - 1)) begin
        h_cnt <= '0;
        if (v_cnt == CNT_W'(V_TOTAL - 1)) v_cnt <= '0;
        else                              v_cnt <= v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  assign h_in = (h_cnt >= CNT_W'(H_ACT_LO)) && (h_cnt < CNT_W'(H_ACT_HI));
  assign v_in = (v_cnt >= CNT_W'(V_ACT_LO)) && (v_cnt < CNT_W'(V_ACT_HI));

  // Address goes upstream straight from the counters so the source has its
  // DATA_LAT cycles to answer before the last pipeline stage samples it.
  assign h_addr = (h_in && v_in) ? ADDR_W'(h_cnt - CNT_W'(H_ACT_LO)) : '0;
  assign v_addr = (h_in && v_in) ? ADDR_W'(v_cnt - CNT_W'(V_ACT_LO)) : '0;

`ifdef VGA_SYNC_FRAME_CNT_EN
  assign ctrl_raw = {(h_cnt >= CNT_W'(H_SYNC)), (v_cnt >= CNT_W'(V_SYNC)),
                     (h_in && v_in), ((h_cnt == '0) && (v_cnt == '0))};
`else
  assign ctrl_raw = {(h_cnt >= CNT_W'(H_SYNC)), (v_cnt >= CNT_W'(V_SYNC)),
                     (h_in && v_in)};
`endif

  // First DATA_LAT stages of the alignment; the final stage sits below so it
  // can capture pixel_data alongside the control bits.
  vga_delay_line #(
    .WIDTH(CTRL_W),
    .DEPTH(DATA_LAT)
  ) u_ctrl_dly (
    .clk    (clk),
    .reset  (reset),
    .clken  (clken),
    .rst_val(CTRL_RST),
    .din    (ctrl_raw),
    .dout   (ctrl_dly)
  );

  // Last stage: colour is gated by the valid bit that arrives with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= CTRL_RST;
      rgb_q  <= '0;
    end else if (clken) begin
      ctrl_q <= ctrl_dly;
      rgb_q  <= ctrl_dly[CTRL_W-3] ? pixel_data : '0;
    end
  end

  assign hsync = ctrl_q[CTRL_W-1];
  assign vsync = ctrl_q[CTRL_W-2];
  assign valid = ctrl_q[CTRL_W-3];
  assign red   = rgb_q[23:16];
  assign green = rgb_q[15:8];
  assign blue  = rgb_q[7:0];

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [15:0] frame_q;

  // Counts on the same edge that launches the sof pulse onto the pins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   frame_q <= '0;
    else if (clken && ctrl_dly[0]) frame_q <= frame_q + 1'b1;
  end

  assign sof       = ctrl_q[0];
  assign frame_cnt = frame_q;
`else
  assign sof       = 1'b0;
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: two instances of vga_sync_gen driven from one clock,
// reset and enable: dut_b with default 640x480 timing and DATA_LAT=1, and
// dut_s with a tiny raster (15x8) and DATA_LAT=2 so whole frames and both
// counter wraps fit in a short run. A reference model computes every output
// from the count of enabled edges since reset; per-scenario tasks add
// targeted timing checks.
module tb_vga_sync_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clken;
  logic        force_white;
  logic [23:0] seed;

  logic [9:0]  h_addr_b, v_addr_b, h_addr_s, v_addr_s;
  logic        hsync_b, vsync_b, valid_b, sof_b;
  logic        hsync_s, vsync_s, valid_s, sof_s;
  logic [7:0]  red_b, green_b, blue_b, red_s, green_s, blue_s;
  logic [15:0] frame_b, frame_s;
  logic [23:0] pix_b, pix_s1, pix_s;

  longint      k = 0;
  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];

  localparam logic [63:0] RST_VAL = {1'b1, 1'b1, 62'h0};

  logic [63:0] act_b, act_s;
  assign act_b = {hsync_b, vsync_b, valid_b, red_b, green_b, blue_b, sof_b, frame_b, h_addr_b, v_addr_b};
  assign act_s = {hsync_s, vsync_s, valid_s, red_s, green_s, blue_s, sof_s, frame_s, h_addr_s, v_addr_s};

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  vga_sync_gen #(.DATA_LAT(1)) dut_b (
    .clk(clk), .reset(rst_n), .clken(clken), .pixel_data(pix_b),
    .h_addr(h_addr_b), .v_addr(v_addr_b), .hsync(hsync_b), .vsync(vsync_b),
    .valid(valid_b), .red(red_b), .green(green_b), .blue(blue_b),
    .sof(sof_b), .frame_cnt(frame_b)
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .DATA_LAT(2)
  ) dut_s (
    .clk(clk), .reset(rst_n), .clken(clken), .pixel_data(pix_s),
    .h_addr(h_addr_s), .v_addr(v_addr_s), .hsync(hsync_s), .vsync(vsync_s),
    .valid(valid_s), .red(red_s), .green(green_s), .blue(blue_s),
    .sof(sof_s), .frame_cnt(frame_s)
  );

  // ---------------- reference model ----------------
  function automatic logic [23:0] color(input int h, input int v, input bit bars);
    if (force_white) return 24'hffffff;
    if (bars) begin
      if (h <= 100) return 24'hff0000;
      if (h <= 200) return 24'h00ff00;
      if (h <= 300) return 24'h0000ff;
    end
    return {h[7:0] ^ seed[7:0], v[7:0] ^ seed[15:8], seed[23:16]};
  endfunction

  // Expected {hsync,vsync,valid,rgb,sof,frame_cnt,h_addr,v_addr} after kk
  // enabled edges since reset release.
  function automatic logic [63:0] model(input longint kk, input int ha, input int hf,
                                        input int hs, input int hb, input int va,
                                        input int vf, input int vs, input int vb,
                                        input int lat, input bit bars);
    int ht, vt, h0, v0, hc, vc;
    longint fr, c;
    logic hsy, vsy, vld, sf;
    logic [23:0] rgb;
    logic [15:0] fc;
    logic [9:0] hae, vae;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    fr = longint'(ht) * longint'(vt);
    h0 = int'(kk % ht);
    v0 = int'((kk / ht) % vt);
    hae = '0;
    vae = '0;
    if (h0 >= hs + hb && h0 < hs + hb + ha && v0 >= vs + vb && v0 < vs + vb + va) begin
      hae = 10'(h0 - hs - hb);
      vae = 10'(v0 - vs - vb);
    end
    hsy = 1'b1; vsy = 1'b1; vld = 1'b0; sf = 1'b0; rgb = '0; fc = '0;
    c = kk - lat - 1;
    if (c >= 0) begin
      hc = int'(c % ht);
      vc = int'((c / ht) % vt);
      hsy = (hc >= hs);
      vsy = (vc >= vs);
      vld = (hc >= hs + hb && hc < hs + hb + ha && vc >= vs + vb && vc < vs + vb + va);
      if (vld) rgb = color(hc - hs - hb, vc - vs - vb, bars);
`ifdef VGA_SYNC_FRAME_CNT_EN
      sf = ((c % fr) == 0);
      fc = 16'((c / fr) + 1);
`endif
    end
    return {hsy, vsy, vld, rgb, sf, fc, hae, vae};
  endfunction

  // Enabled edges since reset, the model's only notion of time.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)     k <= 0;
    else if (clken) k <= k + 1;
  end

  // Upstream pixel sources: registered colour lookup, DATA_LAT deep.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_b <= '0; pix_s1 <= '0; pix_s <= '0;
    end else if (clken) begin
      pix_b  <= color(int'(h_addr_b), int'(v_addr_b), 1'b1);
      pix_s1 <= color(int'(h_addr_s), int'(v_addr_s), 1'b0);
      pix_s  <= pix_s1;
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [63:0] e;
    exp_q.push_back(model(k, 640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b1));
    exp_q.push_back(model(k, 8, 2, 3, 2, 4, 1, 2, 1, 2, 1'b0));
    e = exp_q.pop_front();
    checks++;
    if (act_b !== e) begin
      failures++;
      $display("FAIL big_bundle k=%0d got=%h exp=%h", k, act_b, e);
    end
    e = exp_q.pop_front();
    checks++;
    if (act_s !== e) begin
      failures++;
      $display("FAIL small_bundle k=%0d got=%h exp=%h", k, act_s, e);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input bit white);
    rst_n = 1'b0;
    clken = 1'b0;
    force_white = white;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clken = 1'b1; force_white = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (act_b !== RST_VAL) begin
      failures++; $display("FAIL reset_values got=%h exp=%h", act_b, RST_VAL);
    end
    #1;
    rst_n = 1'b1; clken = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (act_s !== RST_VAL) begin
      failures++; $display("FAIL reset_hold_clken_low got=%h exp=%h", act_s, RST_VAL);
    end
  endtask

  task automatic test_sync_timing();
    int hs_first = -1, hs_end = -1, hs_cnt1 = 0, hs_cnt2 = 0, hs_second = -1;
    int vs_first = -1, vs_cnt = 0, val_first = -1, ha_first = -1;
    logic [23:0] rgb100 = '0, rgb101 = '0;
    do_reset(1'b0);
    clken = 1'b1;
    for (int e = 1; e <= 28250; e++) begin
      @(posedge clk); #1;
      if (!hsync_b) begin
        if (hs_first < 0) hs_first = e;
        if (e <= 800) hs_cnt1++;
        else if (e <= 1600) hs_cnt2++;
        if (e > 800 && hs_second < 0) hs_second = e;
      end
      if (hs_first > 0 && hs_end < 0 && hsync_b) hs_end = e - 1;
      if (e <= 1700 && !vsync_b) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = e;
      end
      if (valid_b && val_first < 0) val_first = e;
      if (h_addr_b != 0 && ha_first < 0) ha_first = e;
      if (e == 28246) rgb100 = {red_b, green_b, blue_b};
      if (e == 28247) rgb101 = {red_b, green_b, blue_b};
    end
    checks++; if (hs_first !== 2) begin failures++; $display("FAIL hsync_first_low got=%0d exp=2", hs_first); end
    checks++; if (hs_end !== 97) begin failures++; $display("FAIL hsync_last_low got=%0d exp=97", hs_end); end
    checks++; if (hs_cnt1 !== 96) begin failures++; $display("FAIL hsync_width_line0 got=%0d exp=96", hs_cnt1); end
    checks++; if (hs_cnt2 !== 96) begin failures++; $display("FAIL hsync_width_line1 got=%0d exp=96", hs_cnt2); end
    checks++; if (hs_second !== 802) begin failures++; $display("FAIL hsync_period got=%0d exp=802", hs_second); end
    checks++; if (vs_first !== 2) begin failures++; $display("FAIL vsync_first_low got=%0d exp=2", vs_first); end
    checks++; if (vs_cnt !== 1600) begin failures++; $display("FAIL vsync_width got=%0d exp=1600", vs_cnt); end
    checks++; if (val_first !== 28146) begin failures++; $display("FAIL first_valid got=%0d exp=28146", val_first); end
    checks++; if (ha_first !== 28145) begin failures++; $display("FAIL first_h_addr got=%0d exp=28145", ha_first); end
    checks++; if (rgb100 !== 24'hff0000) begin failures++; $display("FAIL col100_colour got=%h exp=ff0000", rgb100); end
    checks++; if (rgb101 !== 24'h00ff00) begin failures++; $display("FAIL col101_colour got=%h exp=00ff00", rgb101); end
  endtask

  task automatic test_clken_toggle();
    int low = 0, first = -1, vlow = 0;
    do_reset(1'b0);
    clken = 1'b1;
    for (int p = 1; p <= 1600; p++) begin
      @(posedge clk); #1;
      if (!hsync_b) begin
        low++;
        if (first < 0) first = p;
      end
      if (!vsync_b) vlow++;
      clken = (p % 2 == 0);
    end
    checks++; if (low !== 192) begin failures++; $display("FAIL toggle_hsync_width got=%0d exp=192", low); end
    checks++; if (first !== 3) begin failures++; $display("FAIL toggle_hsync_first got=%0d exp=3", first); end
    checks++; if (vlow !== 1598) begin failures++; $display("FAIL toggle_vsync_low got=%0d exp=1598", vlow); end
  endtask

  task automatic test_wrap_small();
    int vcnt = 0, scnt = 0, exp_s = 0;
    logic [15:0] fc, exp_fc;
    do_reset(1'b0);
    clken = 1'b1;
    for (int e = 1; e <= 363; e++) begin
      @(posedge clk); #1;
      if (valid_s) vcnt++;
      if (sof_s) scnt++;
    end
    fc = frame_s;
`ifdef VGA_SYNC_FRAME_CNT_EN
    exp_s = 4; exp_fc = 16'd4;
`else
    exp_s = 0; exp_fc = 16'd0;
`endif
    checks++; if (vcnt !== 96) begin failures++; $display("FAIL small_valid_3frames got=%0d exp=96", vcnt); end
    checks++; if (scnt !== exp_s) begin failures++; $display("FAIL small_sof_count got=%0d exp=%0d", scnt, exp_s); end
    checks++; if (fc !== exp_fc) begin failures++; $display("FAIL small_frame_cnt got=%0d exp=%0d", fc, exp_fc); end
    // Random enable pattern across further wraps; the scoreboard checks each cycle.
    for (int e = 0; e < 600; e++) begin
      @(posedge clk); #1;
      clken = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic test_blank_mask();
    int leak = 0, white = 0;
    do_reset(1'b1);
    clken = 1'b1;
    for (int e = 1; e <= 300; e++) begin
      @(posedge clk); #1;
      if (!valid_s && {red_s, green_s, blue_s} != 24'h0) leak++;
      if (!valid_b && {red_b, green_b, blue_b} != 24'h0) leak++;
      if (valid_s && {red_s, green_s, blue_s} == 24'hffffff) white++;
    end
    checks++; if (leak !== 0) begin failures++; $display("FAIL blank_rgb_leak got=%0d exp=0", leak); end
    checks++; if (white !== 72) begin failures++; $display("FAIL white_pixels got=%0d exp=72", white); end
  endtask

  task automatic test_mid_reset();
    logic [16:0] got [3];
    logic [16:0] exp_v [3];
    do_reset(1'b0);
    clken = 1'b1;
    repeat (400) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (act_b !== RST_VAL) begin failures++; $display("FAIL midline_reset_big got=%h exp=%h", act_b, RST_VAL); end
    checks++; if (act_s !== RST_VAL) begin failures++; $display("FAIL midline_reset_small got=%h exp=%h", act_s, RST_VAL); end
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1;
      got[e] = {sof_b, frame_b};
    end
`ifdef VGA_SYNC_FRAME_CNT_EN
    exp_v[0] = {1'b0, 16'd0}; exp_v[1] = {1'b1, 16'd1}; exp_v[2] = {1'b0, 16'd1};
`else
    exp_v[0] = '0; exp_v[1] = '0; exp_v[2] = '0;
`endif
    for (int e = 0; e < 3; e++) begin
      checks++;
      if (got[e] !== exp_v[e]) begin
        failures++;
        $display("FAIL sof_after_reset edge=%0d got=%h exp=%h", e + 1, got[e], exp_v[e]);
      end
    end
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    rst_n = 1'b0;
    clken = 1'b0;
    force_white = 1'b0;
    seed = 24'($urandom);
    test_reset();
    test_sync_timing();
    test_clken_toggle();
    test_wrap_small();
    test_blank_mask();
    test_mid_reset();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
